glitc_intercom_tx_framer: RTL and testbench

//  Transmit-side framer for the GLITC intercom link (PHI_UP/PHI_DOWN), running entirely on sysclk.

---
 rtl/glitc_intercom_tx_framer.sv | 104 ++++++++++
 tb/tb_glitc_intercom_tx_framer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/glitc_intercom_tx_framer.sv
// GLITC intercom transmit framer: frames DATA_WIDTH-bit words into START/data/checksum
// nibbles for a 4:1 OSERDES, plus a rotation-unique training pattern for bitslip alignment.
module glitc_intercom_tx_framer #(
  parameter int          DATA_WIDTH    = 16,
  parameter logic [3:0]  TRAIN_PATTERN = 4'b0001,
  parameter logic [3:0]  START_NIBBLE  = 4'hF,
  parameter logic [3:0]  IDLE_NIBBLE   = 4'h0
) (
  input  logic                  sysclk_i,
  input  logic                  rst_n_i,
  input  logic                  train_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [3:0]            oq_o,
  output logic                  busy_o,
  output logic                  training_o,
  output logic [15:0]           frame_count_o
);
  localparam int NN = DATA_WIDTH / 4;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TRAIN, S_START, S_DATA, S_CHECK} state_t;

  state_t                state, bnd_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            csum;
  logic [KW-1:0]         k;
  logic                  accept;

  assign data_ready_o = rst_n_i & ~train_i & ((state == S_IDLE) | (state == S_CHECK));
  assign accept       = data_valid_i & data_ready_o;

  // Frame boundary decision shared by IDLE and CHECK; training beats a pending word.
  always_comb begin
    bnd_state = S_IDLE;
    if (train_i)     bnd_state = S_TRAIN;
    else if (accept) bnd_state = S_START;
  end

  // oq_o/busy_o/training_o are loaded together with the state they describe.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      oq_o          <= IDLE_NIBBLE;
      busy_o        <= 1'b0;
      training_o    <= 1'b0;
      frame_count_o <= 16'h0;
      k             <= '0;
      csum          <= 4'h0;
      shreg         <= '0;
    end else begin
      case (state)
        S_IDLE, S_CHECK: begin
          state      <= bnd_state;
          busy_o     <= (bnd_state == S_START);
          training_o <= (bnd_state == S_TRAIN);
          case (bnd_state)
            S_TRAIN: oq_o <= TRAIN_PATTERN;
            S_START: oq_o <= START_NIBBLE;
            default: oq_o <= IDLE_NIBBLE;
          endcase
          if (accept) begin
            shreg <= data_i;
            csum  <= 4'h0;
          end
        end
        S_TRAIN: begin
          if (!train_i) begin
            state      <= S_IDLE;
            oq_o       <= IDLE_NIBBLE;
            training_o <= 1'b0;
          end
        end
        S_START: begin
          state <= S_DATA;
          k     <= '0;
          oq_o  <= shreg[3:0];
          csum  <= csum ^ shreg[3:0];
          shreg <= {4'h0, shreg[DATA_WIDTH-1:4]};
        end
        S_DATA: begin
          if (k == KW'(NN - 1)) begin
            // csum already folds in every nibble launched so far
            state         <= S_CHECK;
            oq_o          <= csum;
            frame_count_o <= frame_count_o + 16'h1;
          end else begin
            k     <= k + 1'b1;
            oq_o  <= shreg[3:0];
            csum  <= csum ^ shreg[3:0];
            shreg <= {4'h0, shreg[DATA_WIDTH-1:4]};
          end
        end
        default: begin
          state      <= S_IDLE;
          oq_o       <= IDLE_NIBBLE;
          busy_o     <= 1'b0;
          training_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_glitc_intercom_tx_framer.sv
// Directed bench for glitc_intercom_tx_framer (DATA_WIDTH=16, default nibbles).
module tb_glitc_intercom_tx_framer;
  logic        clk = 1'b0;
  logic        rst_n, train, valid, ready, busy, training;
  logic [15:0] data, fc;
  logic [3:0]  oq;
  int          errors = 0;
  int          checks = 0;

  glitc_intercom_tx_framer #(.DATA_WIDTH(16)) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .train_i(train), .data_i(data),
    .data_valid_i(valid), .data_ready_o(ready), .oq_o(oq), .busy_o(busy),
    .training_o(training), .frame_count_o(fc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp2 [6];
  logic [3:0] exp3 [12];

  initial begin
    exp2 = '{4'hF, 4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
    exp3 = '{4'hF, 4'h4, 4'h3, 4'h2, 4'h1, 4'h4, 4'hF, 4'hD, 4'hC, 4'hB, 4'hA, 4'h0};
    rst_n = 1'b0; train = 1'b0; valid = 1'b0; data = 16'h0;

    // 1: reset state and quiet idle line
    step(); step();
    chk("rst_oq", oq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_training", training, 0);
    chk("rst_fc", fc, 0);
    chk("rst_ready_low", ready, 0);
    rst_n = 1'b1;
    #1 chk("idle_ready", ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_oq", oq, 0);
      chk("idle_busy", busy, 0);
    end

    // 2: single word
    data = 16'h1234; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) valid = 1'b0;
      chk($sformatf("single_oq%0d", i), oq, exp2[i]);
      chk($sformatf("single_busy%0d", i), busy, 1);
      if (i == 2) chk("single_ready_data", ready, 0);
    end
    chk("single_fc", fc, 1);
    step();
    chk("single_tail_oq", oq, 0);
    chk("single_tail_busy", busy, 0);

    // 3: back-to-back words
    data = 16'h1234; valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) data = 16'hABCD;
      chk($sformatf("b2b_oq%0d", i), oq, exp3[i]);
      if (i == 2) chk("b2b_ready_data", ready, 0);
      if (i == 5) chk("b2b_ready_check", ready, 1);
      if (i == 6) valid = 1'b0;
    end
    chk("b2b_fc", fc, 3);
    step();
    chk("b2b_tail_oq", oq, 0);
    chk("b2b_tail_busy", busy, 0);

    // 4: training from idle
    train = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("train_oq%0d", i), oq, 1);
      chk("train_flag", training, 1);
      chk("train_ready", ready, 0);
    end
    train = 1'b0;
    step();
    chk("post_train_oq", oq, 0);
    chk("post_train_flag", training, 0);
    data = 16'h1234; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("post_train_start", oq, 4'hF);
    for (int i = 1; i < 6; i++) begin
      step();
      chk($sformatf("post_train_oq%0d", i), oq, exp2[i]);
    end
    chk("post_train_fc", fc, 4);
    step();

    // 5: train raised mid-frame, pending word at boundary refused
    data = 16'h1234; valid = 1'b1;
    step(); valid = 1'b0;
    chk("mid_train_start", oq, 4'hF);
    step(); step();
    chk("mid_train_n1", oq, 4'h3);
    train = 1'b1; valid = 1'b1; data = 16'h5555;
    step(); chk("mid_train_n2", oq, 4'h2);
    step(); chk("mid_train_n3", oq, 4'h1);
    step(); chk("mid_train_csum", oq, 4'h4);
    #1 chk("mid_train_ready", ready, 0);
    chk("mid_train_fc", fc, 5);
    step();
    chk("mid_train_pat", oq, 1);
    chk("mid_train_flag", training, 1);
    chk("mid_train_busy", busy, 0);
    train = 1'b0; valid = 1'b0;
    step();
    chk("mid_train_idle", oq, 0);
    step();
    chk("mid_train_no_accept", busy, 0);

    // 6: reset during DATA nibble 2
    data = 16'h1234; valid = 1'b1;
    step(); valid = 1'b0;
    step(); step(); step();
    chk("abort_n2", oq, 4'h2);
    rst_n = 1'b0;
    step();
    chk("abort_oq", oq, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fc", fc, 0);
    rst_n = 1'b1;
    step();
    chk("abort_idle", oq, 0);
    data = 16'h1234; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) valid = 1'b0;
      chk($sformatf("recover_oq%0d", i), oq, exp2[i]);
    end
    chk("recover_fc", fc, 1);
    step();

    // 7: frame counter wrap
    force dut.frame_count_o = 16'hFFFF;
    #1 release dut.frame_count_o;
    #1 chk("wrap_preload", fc, 16'hFFFF);
    data = 16'h1234; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) valid = 1'b0;
      if (i == 4) chk("wrap_before", fc, 16'hFFFF);
    end
    chk("wrap_csum", oq, 4'h4);
    chk("wrap_fc", fc, 16'h0000);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
